// File: rtl/cpu_pkg.sv
// Shared CPU package: default datapath widths and the helper that locates one
// port's field inside a packed multi-port bus.
package cpu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // LSB position of field idx in a packed bus of w-bit fields
   function automatic int slice_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/pipe_regfile_if.sv
// Register-file bus: two write ports, NRD packed read ports and the
// issue-side scoreboard set/observe signals.
interface pipe_regfile_if
   import cpu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NRD    = 2
);
   logic                     we0;
   logic                     we1;
   logic [ADDR_W-1:0]        wa0;
   logic [ADDR_W-1:0]        wa1;
   logic [DATA_W-1:0]        wd0;
   logic [DATA_W-1:0]        wd1;
   logic [NRD*ADDR_W-1:0]    ra;
   logic [NRD*DATA_W-1:0]    rd;
   logic [NRD-1:0]           rbusy;
   logic                     set_en;
   logic [ADDR_W-1:0]        set_a;
   logic [(2**ADDR_W)-1:0]   busy_vec;
   logic [31:0]              wr_cnt;

   modport master (
      output we0, we1, wa0, wa1, wd0, wd1, ra, set_en, set_a,
      input  rd, rbusy, busy_vec, wr_cnt
   );

   modport slave (
      input  we0, we1, wa0, wa1, wd0, wd1, ra, set_en, set_a,
      output rd, rbusy, busy_vec, wr_cnt
   );
endinterface

// File: rtl/rf_fwd_mux.sv
// One read port's data/busy selection: stored value, same-cycle write bypass
// (write port 1 has priority) and forced zero for register 0.
module rf_fwd_mux #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int FWD      = 1,
   parameter int ZERO_REG = 1
) (
   input  logic [ADDR_W-1:0] ra,
   input  logic [DATA_W-1:0] stored,
   input  logic              busy_bit,
   input  logic              wv0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              wv1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   input  logic              set_hit,
   output logic [DATA_W-1:0] rd,
   output logic              rbusy
);
   logic hit0;
   logic hit1;

   assign hit0 = wv0 && (wa0 == ra);
   assign hit1 = wv1 && (wa1 == ra);

   always_comb begin
      rd    = stored;
      rbusy = busy_bit;
      if (FWD != 0) begin
         if (hit1)      rd = wd1;
         else if (hit0) rd = wd0;
         // the write retires the producer unless a new one issues this cycle
         if ((hit0 || hit1) && !set_hit) rbusy = 1'b0;
      end
      if (ZERO_REG != 0 && ra == '0) rd = '0;
   end
endmodule

// File: rtl/pipe_regfile.sv
// Two-write, NRD-read flop register file with issue scoreboard and a
// committed-write counter.
module pipe_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NRD      = 2,
   parameter int FWD      = 1,
   parameter int ZERO_REG = 1
) (
   input  logic           clk,
   input  logic           reset,
   pipe_regfile_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [31:0]       wr_cnt_q;
   logic              wv0;
   logic              wv1;
   logic              sv;

   // effective writes: register-0 discards removed, port 0 dropped on a same-address collision
   assign wv1 = bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0);
   assign wv0 = bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0) &&
                !(wv1 && bus.wa1 == bus.wa0);
   assign sv  = bus.set_en && !(ZERO_REG != 0 && bus.set_a == '0);

   always_comb begin
      busy_nxt = busy;
      if (wv0) busy_nxt[bus.wa0] = 1'b0;
      if (wv1) busy_nxt[bus.wa1] = 1'b0;
      if (sv)  busy_nxt[bus.set_a] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
         busy     <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (wv0) mem[bus.wa0] <= bus.wd0;
         if (wv1) mem[bus.wa1] <= bus.wd1;
         busy     <= busy_nxt;
         wr_cnt_q <= wr_cnt_q + 32'(wv0) + 32'(wv1);
      end
   end

   assign bus.busy_vec = busy;
   assign bus.wr_cnt   = wr_cnt_q;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra_i;
      logic [DATA_W-1:0] rd_i;
      logic              rbusy_i;

      assign ra_i = bus.ra[slice_lsb(i, ADDR_W) +: ADDR_W];

      rf_fwd_mux #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .FWD      (FWD),
         .ZERO_REG (ZERO_REG)
      ) u_mux (
         .ra       (ra_i),
         .stored   (mem[ra_i]),
         .busy_bit (busy[ra_i]),
         .wv0      (wv0),
         .wa0      (bus.wa0),
         .wd0      (bus.wd0),
         .wv1      (wv1),
         .wa1      (bus.wa1),
         .wd1      (bus.wd1),
         .set_hit  (sv && bus.set_a == ra_i),
         .rd       (rd_i),
         .rbusy    (rbusy_i)
      );

      assign bus.rd[slice_lsb(i, DATA_W) +: DATA_W] = rd_i;
      assign bus.rbusy[i]                           = rbusy_i;
   end
endmodule
